// File: rtl/race_pkg.sv
// Shared race constants: state bus codes seen by both physics engines, winner codes.
// Pure definitions, no timing or flow control.
package race_pkg;

    typedef logic [2:0] race_state_t;

    localparam race_state_t ST_IDLE      = 3'd0;
    localparam race_state_t ST_SETTING   = 3'd1;
    localparam race_state_t ST_COUNTDOWN = 3'd3;
    localparam race_state_t ST_RACING    = 3'd4;
    localparam race_state_t ST_PAUSE     = 3'd5;
    localparam race_state_t ST_FINISH    = 3'd6;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;
    localparam logic [1:0] WIN_TIE  = 2'd3;

    localparam int SUBSEC_TICKS = 100;

    // Bit order matches WIN_* so both-high naturally encodes a tie.
    function automatic logic [1:0] winner_code(input logic p1, input logic p2);
        return {p2, p1};
    endfunction

endpackage

// File: rtl/race_sequencer_if.sv
// Button pulses and engine finish flags in, race state bus and timing outputs out.
// Plain wires; no handshake, every output is valid every cycle.
interface race_sequencer_if;
    import race_pkg::*;

    logic        start_p;
    logic        pause_p;
    logic        abort_p;
    logic        p1_finish;
    logic        p2_finish;
    race_state_t state;
    logic [1:0]  countdown;
    logic        go_pulse;
    logic [15:0] race_cs;
    logic [1:0]  winner;

    modport master (
        input  start_p, pause_p, abort_p, p1_finish, p2_finish,
        output state, countdown, go_pulse, race_cs, winner
    );

    modport slave (
        output start_p, pause_p, abort_p, p1_finish, p2_finish,
        input  state, countdown, go_pulse, race_cs, winner
    );

endinterface

// File: rtl/cs_prescaler.sv
// Centisecond prescaler: counts 0..CS_CYCLES-1 while enabled, holds otherwise.
// tick is combinational from the held count and en; no backpressure.
module cs_prescaler #(
    parameter int CS_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (CS_CYCLES > 1) ? $clog2(CS_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CS_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/race_sequencer.sv
// Race FSM driving the engines' state bus, plus countdown, race timer and winner latch.
// All outputs registered, one cycle after the sampled pulse; pulses are never stalled.
module race_sequencer
    import race_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int CS_CYCLES = CLK_FREQ / 100,
    parameter int CD_START  = 3,
    parameter int TIME_MAX  = 59999
) (
    input  logic              clk,
    input  logic              rst,
    race_sequencer_if.master  bus
);

    race_state_t state_q, state_d;
    logic [1:0]  cd_q, cd_d;
    logic        go_q, go_d;
    logic [15:0] cs_q, cs_d;
    logic [1:0]  win_q, win_d;
    logic [6:0]  sub_q, sub_d;

    logic ps_clr;
    logic ps_en;
    logic tick;
    logic finish_any;
    logic state_valid;

    assign finish_any  = bus.p1_finish | bus.p2_finish;
    assign state_valid = (state_q != 3'd2) && (state_q != 3'd7);

    // The prescaler only runs in cycles that stay in COUNTDOWN/RACING, so a
    // finishing cycle never bumps race_cs and pause freezes it mid-count.
    assign ps_en  = !bus.abort_p &&
                    ((state_q == ST_COUNTDOWN) ||
                     ((state_q == ST_RACING) && !finish_any));
    assign ps_clr = bus.abort_p || !state_valid ||
                    ((state_q == ST_SETTING) && bus.start_p);

    cs_prescaler #(
        .CS_CYCLES (CS_CYCLES)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (ps_clr),
        .en   (ps_en),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        go_d    = 1'b0;
        cs_d    = cs_q;
        win_d   = win_q;
        sub_d   = sub_q;

        if (bus.abort_p || !state_valid) begin
            state_d = ST_IDLE;
            cd_d    = 2'd0;
            cs_d    = 16'd0;
            win_d   = WIN_NONE;
            sub_d   = 7'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_p) state_d = ST_SETTING;
                end
                ST_SETTING: begin
                    if (bus.start_p) begin
                        state_d = ST_COUNTDOWN;
                        cd_d    = 2'(CD_START);
                        cs_d    = 16'd0;
                        sub_d   = 7'd0;
                    end
                end
                ST_COUNTDOWN: begin
                    if (tick) begin
                        if (sub_q == 7'(SUBSEC_TICKS - 1)) begin
                            sub_d = 7'd0;
                            if (cd_q == 2'd1) begin
                                state_d = ST_RACING;
                                cd_d    = 2'd0;
                                go_d    = 1'b1;
                            end else begin
                                cd_d = cd_q - 2'd1;
                            end
                        end else begin
                            sub_d = sub_q + 7'd1;
                        end
                    end
                end
                ST_RACING: begin
                    if (finish_any) begin
                        state_d = ST_FINISH;
                        win_d   = winner_code(bus.p1_finish, bus.p2_finish);
                    end else begin
                        if (tick && (cs_q < 16'(TIME_MAX))) cs_d = cs_q + 16'd1;
                        if (bus.pause_p) state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (bus.pause_p) state_d = ST_RACING;
                end
                ST_FINISH: begin
                    if (bus.start_p) begin
                        state_d = ST_IDLE;
                        cs_d    = 16'd0;
                        win_d   = WIN_NONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cd_q    <= 2'd0;
            go_q    <= 1'b0;
            cs_q    <= 16'd0;
            win_q   <= WIN_NONE;
            sub_q   <= 7'd0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            go_q    <= go_d;
            cs_q    <= cs_d;
            win_q   <= win_d;
            sub_q   <= sub_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.countdown = cd_q;
    assign bus.go_pulse  = go_q;
    assign bus.race_cs   = cs_q;
    assign bus.winner    = win_q;

endmodule

// File: tb/tb_race_sequencer.sv
// Randomized bench for race_sequencer: a cycle-level reference model feeds a queue
// of expected outputs that a separate monitor compares against the DUT.
module tb_race_sequencer;
    import race_pkg::*;

    localparam int CS   = 10;
    localparam int CDS  = 3;
    localparam int TMAX = 120;
    localparam int SEC  = SUBSEC_TICKS * CS;

    typedef struct packed {
        logic [2:0]  st;
        logic [1:0]  cd;
        logic        go;
        logic [15:0] cs;
        logic [1:0]  win;
    } snap_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    race_sequencer_if bus ();

    race_sequencer #(
        .CLK_FREQ (1000),
        .CD_START (CDS),
        .TIME_MAX (TMAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: time is tracked as elapsed cycles, outputs derived arithmetically.
    logic [2:0] m_st  = ST_IDLE;
    int         m_cd  = 0;   // cycles spent in COUNTDOWN
    int         m_act = 0;   // race cycles that counted toward the timer
    logic [1:0] m_win = 0;
    logic       m_go  = 0;
    snap_t      exp_q[$];

    always @(posedge clk) begin
        snap_t e;
        int    cs_now;
        m_go = 1'b0;
        if (rst) begin
            m_st = ST_IDLE; m_cd = 0; m_act = 0; m_win = 0;
        end else if (bus.abort_p) begin
            m_st = ST_IDLE; m_cd = 0; m_act = 0; m_win = 0;
        end else begin
            case (m_st)
                ST_IDLE:    if (bus.start_p) m_st = ST_SETTING;
                ST_SETTING: if (bus.start_p) begin m_st = ST_COUNTDOWN; m_cd = 0; m_act = 0; end
                ST_COUNTDOWN: begin
                    m_cd++;
                    if (m_cd == CDS * SEC) begin m_st = ST_RACING; m_go = 1'b1; end
                end
                ST_RACING: begin
                    if (bus.p1_finish || bus.p2_finish) begin
                        m_st  = ST_FINISH;
                        m_win = (bus.p1_finish && bus.p2_finish) ? WIN_TIE :
                                bus.p1_finish ? WIN_P1 : WIN_P2;
                    end else begin
                        m_act++;
                        if (bus.pause_p) m_st = ST_PAUSE;
                    end
                end
                ST_PAUSE:  if (bus.pause_p) m_st = ST_RACING;
                ST_FINISH: if (bus.start_p) begin m_st = ST_IDLE; m_act = 0; m_win = 0; end
                default:   m_st = ST_IDLE;
            endcase
        end
        cs_now = m_act / CS;
        if (cs_now > TMAX) cs_now = TMAX;
        e.st  = m_st;
        e.cd  = (m_st == ST_COUNTDOWN) ? 2'(CDS - m_cd / SEC) : 2'd0;
        e.go  = m_go;
        e.cs  = 16'(cs_now);
        e.win = m_win;
        exp_q.push_back(e);
    end

    // Monitor: compare whenever either the expected or the observed outputs move.
    snap_t prev_e, prev_a;
    bit    started = 0;
    always @(negedge clk) begin
        snap_t e, a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {bus.state, bus.countdown, bus.go_pulse, bus.race_cs, bus.winner};
            if (!started || e != prev_e || a != prev_a) begin
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs @%0t: got state=%0d cd=%0d go=%0d cs=%0d win=%0d, required state=%0d cd=%0d go=%0d cs=%0d win=%0d",
                             $time, a.st, a.cd, a.go, a.cs, a.win, e.st, e.cd, e.go, e.cs, e.win);
                end
            end
            prev_e  = e;
            prev_a  = a;
            started = 1;
        end
    end

    task automatic pulse(input logic s, input logic p, input logic a,
                         input logic f1, input logic f2);
        bus.start_p = s; bus.pause_p = p; bus.abort_p = a;
        bus.p1_finish = f1; bus.p2_finish = f2;
        @(negedge clk);
        bus.start_p = 0; bus.pause_p = 0; bus.abort_p = 0;
        bus.p1_finish = 0; bus.p2_finish = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n = 0;
        while (bus.state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.state !== s) begin
            errors++;
            $display("FAIL wait_state: state=%0d required=%0d within %0d cycles", bus.state, s, budget);
        end
    endtask

    task automatic start_race();
        pulse(1, 0, 0, 0, 0);
        pulse(1, 0, 0, 0, 0);
        wait_state(ST_RACING, CDS * SEC + 20);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_p = 0; bus.pause_p = 0; bus.abort_p = 0;
        bus.p1_finish = 0; bus.p2_finish = 0;
        idle(3);
        rst = 0;
        idle(2);

        // Basic race with pause mid-prescaler, then P2 wins.
        start_race();
        idle(404);
        pulse(0, 1, 0, 0, 0);
        idle(500);
        pulse(0, 1, 0, 0, 0);
        idle($urandom_range(30, 80));
        pulse(0, 0, 0, 0, 1);
        idle(20);
        pulse(1, 0, 0, 0, 0);
        idle(5);

        // Saturation, then a tie.
        start_race();
        idle(TMAX * CS + 100);
        pulse(0, 0, 0, 1, 1);
        idle(10);
        pulse(1, 0, 0, 0, 0);
        idle(3);

        // Finish and pause together: finish takes priority.
        start_race();
        idle($urandom_range(5, 60));
        pulse(0, 1, 0, 1, 0);
        idle(10);
        pulse(1, 0, 0, 0, 0);

        // Abort during countdown with countdown=2; start/pause ignored there.
        pulse(1, 0, 0, 0, 0);
        pulse(1, 0, 0, 0, 0);
        idle(100);
        pulse(1, 1, 0, 0, 0);
        idle(SEC + $urandom_range(0, 500));
        pulse(0, 0, 1, 0, 0);
        idle(5);

        // Finish inputs held during pause, then reset mid-race.
        start_race();
        idle($urandom_range(20, 90));
        pulse(0, 1, 0, 0, 0);
        bus.p1_finish = 1; bus.p2_finish = 1;
        idle(50);
        bus.p1_finish = 0; bus.p2_finish = 0;
        pulse(0, 1, 0, 0, 0);
        idle($urandom_range(10, 50));
        rst = 1;
        idle(1);
        rst = 0;
        idle(5);

        // Random pulse traffic.
        for (int i = 0; i < 12000; i++) begin
            bus.start_p   = ($urandom_range(0, 59) == 0);
            bus.pause_p   = ($urandom_range(0, 39) == 0);
            bus.abort_p   = ($urandom_range(0, 2999) == 0);
            bus.p1_finish = ($urandom_range(0, 299) == 0);
            bus.p2_finish = ($urandom_range(0, 299) == 0);
            rst           = ($urandom_range(0, 4999) == 0);
            @(negedge clk);
        end
        bus.start_p = 0; bus.pause_p = 0; bus.abort_p = 0;
        bus.p1_finish = 0; bus.p2_finish = 0;
        rst = 0;
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
